// File: rtl/boot_loader_pkg.sv
// Shared defines for the boot loader: codebase widths, header/word framing and FSM encoding.
package boot_loader_pkg;

    localparam int unsigned datawidth      = 32;
    localparam int unsigned im_addr_width  = 8;
    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = datawidth / 8;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: shifts MSB-first bytes into a word and pulses word_done the cycle after the last byte.
module byte_packer
    import boot_loader_pkg::*;
#(
    parameter int unsigned BPW = BYTES_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [7:0]           data,
    output logic                 last,
    output logic [BPW*8-1:0]     word,
    output logic                 word_done
);

    localparam int unsigned DW   = BPW * 8;
    localparam int unsigned CW   = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;
    logic [DW-1:0] sr;

    always_comb begin
        last = valid && (cnt == CW'(BPW - 1));
        word = sr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= last;
            if (valid) begin
                sr  <= {sr[DW-9:0], data};
                cnt <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a length-prefixed word image from a byte stream into instruction memory,
// holding the CPU in reset until done. Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned DATAWIDTH = datawidth,
    parameter int unsigned IM_ADDR_W = im_addr_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    output logic                 rx_ready_o,
    output logic                 im_we_o,
    output logic [IM_ADDR_W-1:0] im_addr_o,
    output logic [DATAWIDTH-1:0] im_din_o,
    output logic                 cpu_rst_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned CNT_W = HDR_LEN * 8;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t               state;
    state_t               next_state;
    logic [7:0]           cnt_hi;
    logic [CNT_W-1:0]     remaining;
    logic [IM_ADDR_W-1:0] index;
    logic                 xfer;
    logic                 pack_valid;
    logic                 last;
    logic                 word_done;
    logic [DATAWIDTH-1:0] word;
    logic                 err;
    logic                 done;

    assign xfer       = rx_valid_i && rx_ready_o;
    assign pack_valid = xfer && (state == DATA);

    byte_packer #(
        .BPW (DATAWIDTH / 8)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .valid     (pack_valid),
        .data      (rx_data_i),
        .last      (last),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR0;
            cnt_hi    <= '0;
            remaining <= '0;
            index     <= '0;
        end else begin
            state <= next_state;
            if (xfer && state == HDR0)
                cnt_hi <= rx_data_i;
            if (xfer && state == HDR1)
                remaining <= {cnt_hi, rx_data_i};
            else if (last)
                remaining <= remaining - CNT_W'(1);
            if (word_done)
                index <= index + IM_ADDR_W'(1);
        end
    end

    // Leave DATA on the final byte so DONE coincides with the last word's write strobe.
    always_comb begin
        next_state = state;
        unique case (state)
            HDR0: if (xfer) next_state = HDR1;
            HDR1: if (xfer) next_state = ({cnt_hi, rx_data_i} == '0) ? AFTER_DATA : DATA;
            DATA: if (last && remaining == CNT_W'(1)) next_state = AFTER_DATA;
            CHK:  if (xfer) next_state = DONE;
            DONE: next_state = DONE;
            default: next_state = HDR0;
        endcase
    end

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (xfer) begin
            if (state == CHK) begin
                if (rx_data_i != csum)
                    err <= 1'b1;
            end else begin
                csum <= csum ^ rx_data_i;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        done       = (state == DONE) && !err;
        rx_ready_o = (state != DONE);
        done_o     = done;
        cpu_rst_o  = !done;
        err_o      = err;
        im_we_o    = word_done;
        im_addr_o  = index;
        im_din_o   = word;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter DATAWIDTH, default 32: instruction word width, equal to the codebase's datawidth.
REQ-002 Parameter IM_ADDR_W, default 8: instruction memory address width, equal to the codebase's im_addr_width.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rx_valid_i  input  1  byte-stream source has a byte.
REQ-006 rx_data_i  input  8  byte from the stream.
REQ-007 rx_ready_o  output  1  loader accepts the byte.
REQ-008 im_we_o  output  1  instruction memory write strobe.
REQ-009 im_addr_o  output  IM_ADDR_W  instruction memory write address.
REQ-010 im_din_o  output  DATAWIDTH  instruction word to write.
REQ-011 cpu_rst_o  output  1  holds cpu_core in reset while loading.
REQ-012 done_o  output  1  image loaded, CPU released.
REQ-013 err_o  output  1  checksum failure; sticky until rst.

Function
REQ-014 A byte transfer occurs on the rising edge where rx_valid_i and rx_ready_o are both 1.
REQ-015 Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each (MSB first).
REQ-016 FSM states: HDR0 -> HDR1 -> DATA -> DONE, plus CHK when BOOT_CHECKSUM_EN is defined; each state advances only on a transfer.
REQ-017 rx_ready_o is 1 in HDR0, HDR1, DATA and CHK, and 0 in DONE.
REQ-018 In HDR1, N=0 goes directly to DONE (or CHK), with no write.
REQ-019 Each 4th byte of a word completes a word. On the following cycle im_we_o=1 for exactly one cycle, with im_din_o holding the assembled word and im_addr_o holding the word index.
REQ-020 The word index starts at 0 and increments after each write, wrapping modulo 2^IM_ADDR_W when N exceeds memory depth (later words overwrite earlier ones).
REQ-021 Transfers are accepted back-to-back every cycle; a registered write never stalls the byte stream.
REQ-022 The last word's write completes before, or in the same cycle as, the state becoming DONE.
REQ-023 In DONE: cpu_rst_o=0 and done_o=1. All rx traffic is ignored until rst.
REQ-024 Gaps (rx_valid_i=0) at any point leave the byte counter, the word index and the partial word unchanged.

Reset
REQ-025 rst=1 at any point, including mid-word or mid-header, returns the FSM to HDR0 on the next edge. The partial word, the byte counter, the word count and the word index are discarded.
REQ-026 Reset values: rx_ready_o=1 (registered, valid the first cycle after rst deasserts), im_we_o=0, im_addr_o=0, im_din_o=0, cpu_rst_o=1, done_o=0, err_o=0.
REQ-027 A write strobe pending when rst asserts is suppressed.

Configuration
REQ-028 With BOOT_CHECKSUM_EN defined, one trailing byte follows the data in state CHK. It is compared with the XOR of all header and data bytes.
REQ-029 On a checksum match the FSM goes to DONE. On a mismatch err_o=1, cpu_rst_o stays 1, done_o stays 0, and the FSM parks in DONE with rx_ready_o=0.
REQ-030 With BOOT_CHECKSUM_EN undefined, there is no CHK state, no trailing byte, and err_o is tied to 0.

Structure
REQ-031 The FSM state encoding, the header length (2) and the bytes-per-word count (DATAWIDTH/8) belong in the shared defines file alongside datawidth and im_addr_width.
REQ-032 A single sub-module, byte_packer, handles byte-to-word assembly: shift register, byte counter, word-complete pulse. The FSM, word index and checksum stay in boot_loader.

Verification
REQ-033 N=2, bytes 00 02 11 22 33 44 AA BB CC DD, back-to-back -> writes 0x11223344@0, then 0xAABBCCDD@1, one cycle apart by 4. done_o=1 and cpu_rst_o=0 after the last write.
REQ-034 N=0 -> no im_we_o pulse; done_o=1 two transfers after rst release.
REQ-035 N=1 with rx_valid_i toggling 1/0 each cycle -> a single write of the correct word. Byte count and index are unaffected by the gaps.
REQ-036 rst asserted after 2 data bytes, then a fresh N=1 stream 00 01 DE AD BE EF -> exactly one write, 0xDEADBEEF@0, and no stale bytes.
REQ-037 IM_ADDR_W=2, N=5 -> addresses 0,1,2,3,0; the 5th word overwrites address 0.
REQ-038 BOOT_CHECKSUM_EN with N=1 00 01 01 02 03 04 then checksum 0x05 -> done_o=1. With checksum 0x06 instead -> err_o=1, cpu_rst_o=1, rx_ready_o=0.
